// File: rtl/ins_mem_loader.sv
// Instruction memory filled from UART RX bytes during a load session and then read by PC.
// Optional macro INS_MEM_CHECKSUM_EN adds Checksum_out, the XOR of every byte of every word that was stored.
module ins_mem_loader #(
    parameter int INS_W  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Load_INS_en_in,
    input  logic              Rx_Valid_in,
    input  logic [7:0]        Rx_Byte_in,
    input  logic              Fetch_en_in,
    input  logic [ADDR_W-1:0] PC_in,
    output logic [INS_W-1:0]  INS_out,
    output logic              INS_valid_out,
    output logic              Load_done_out,
    output logic [ADDR_W:0]   INS_count_out,
    output logic              Overflow_out
`ifdef INS_MEM_CHECKSUM_EN
    ,
    output logic [7:0]        Checksum_out
`endif
);

    localparam int BYTES  = INS_W / 8;
    localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES - 1);
    localparam logic [ADDR_W:0]   FULL      = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {
        IDLE,
        LOAD
    } state_t;

    state_t              state_q, state_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [INS_W-1:0]    word_q, word_d;
    logic [INS_W-1:0]    ins_q, ins_d;
    logic                ins_valid_q, ins_valid_d;
    logic                load_done_q, load_done_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                overflow_q, overflow_d;
`ifdef INS_MEM_CHECKSUM_EN
    logic [7:0]          csum_part_q, csum_part_d;
    logic [7:0]          checksum_q, checksum_d;
    logic [7:0]          csum_v;
`endif

    logic                take_byte;
    logic [INS_W-1:0]    word_v;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [INS_W-1:0]    mem_wdata;
    logic [INS_W-1:0]    mem [DEPTH];

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        wr_ptr_d    = wr_ptr_q;
        word_d      = word_q;
        ins_d       = ins_q;
        ins_valid_d = 1'b0;
        load_done_d = load_done_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        take_byte   = 1'b0;
        word_v      = word_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_q;
        mem_wdata   = word_q;
`ifdef INS_MEM_CHECKSUM_EN
        csum_part_d = csum_part_q;
        checksum_d  = checksum_q;
        csum_v      = csum_part_q;
`endif

        case (state_q)
            IDLE: begin
                if (Load_INS_en_in) begin
                    state_d     = LOAD;
                    lane_d      = '0;
                    wr_ptr_d    = '0;
                    count_d     = '0;
                    overflow_d  = 1'b0;
                    load_done_d = 1'b0;
`ifdef INS_MEM_CHECKSUM_EN
                    csum_part_d = '0;
                    checksum_d  = '0;
`endif
                    take_byte   = Rx_Valid_in;
                end else if (Fetch_en_in) begin
                    if ({1'b0, PC_in} < count_q) begin
                        ins_d       = mem[PC_in];
                        ins_valid_d = 1'b1;
                    end else begin
                        ins_d = '0;
                    end
                end
            end
            LOAD: begin
                if (!Load_INS_en_in) begin
                    // Ending the session drops any partially assembled word.
                    state_d     = IDLE;
                    load_done_d = 1'b1;
                    lane_d      = '0;
`ifdef INS_MEM_CHECKSUM_EN
                    csum_part_d = '0;
`endif
                end else begin
                    take_byte = Rx_Valid_in;
                end
            end
            default: state_d = IDLE;
        endcase

        // lane_d/wr_ptr_d/count_d already hold session-start values on the entry cycle.
        if (take_byte) begin
            for (int b = 0; b < BYTES; b++) begin
                if (lane_d == LANE_W'(b)) word_v[b*8 +: 8] = Rx_Byte_in;
            end
            word_d = word_v;
`ifdef INS_MEM_CHECKSUM_EN
            csum_v = csum_part_d ^ Rx_Byte_in;
`endif
            if (lane_d == LAST_LANE) begin
                lane_d = '0;
`ifdef INS_MEM_CHECKSUM_EN
                csum_part_d = '0;
`endif
                if (count_d != FULL) begin
                    mem_we    = 1'b1;
                    mem_waddr = wr_ptr_d;
                    mem_wdata = word_v;
                    wr_ptr_d  = wr_ptr_d + 1'b1;
                    count_d   = count_d + 1'b1;
`ifdef INS_MEM_CHECKSUM_EN
                    checksum_d = checksum_d ^ csum_v;
`endif
                end else begin
                    overflow_d = 1'b1;
                end
            end else begin
                lane_d = lane_d + 1'b1;
`ifdef INS_MEM_CHECKSUM_EN
                csum_part_d = csum_v;
`endif
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            lane_q      <= '0;
            wr_ptr_q    <= '0;
            ins_q       <= '0;
            ins_valid_q <= 1'b0;
            load_done_q <= 1'b0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
`ifdef INS_MEM_CHECKSUM_EN
            csum_part_q <= '0;
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            wr_ptr_q    <= wr_ptr_d;
            ins_q       <= ins_d;
            ins_valid_q <= ins_valid_d;
            load_done_q <= load_done_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
`ifdef INS_MEM_CHECKSUM_EN
            csum_part_q <= csum_part_d;
            checksum_q  <= checksum_d;
`endif
        end
    end

    // Assembly buffer and storage array carry data only, so they have no reset.
    always_ff @(posedge CLK) begin
        word_q <= word_d;
        if (mem_we && !RST) mem[mem_waddr] <= mem_wdata;
    end

    assign INS_out       = ins_q;
    assign INS_valid_out = ins_valid_q;
    assign Load_done_out = load_done_q;
    assign INS_count_out = count_q;
    assign Overflow_out  = overflow_q;
`ifdef INS_MEM_CHECKSUM_EN
    assign Checksum_out  = checksum_q;
`endif

endmodule

// File: tb/tb_ins_mem_loader.sv
// Scoreboard bench for ins_mem_loader with INS_W=16, DEPTH=4 (checksum checks when INS_MEM_CHECKSUM_EN is defined).
module tb_ins_mem_loader;

    localparam int INS_W  = 16;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              load_en;
    logic              rx_valid;
    logic [7:0]        rx_byte;
    logic              fetch_en;
    logic [ADDR_W-1:0] pc;
    logic [INS_W-1:0]  ins_out;
    logic              ins_valid;
    logic              load_done;
    logic [ADDR_W:0]   ins_count;
    logic              overflow;
`ifdef INS_MEM_CHECKSUM_EN
    logic [7:0]        checksum;
`endif

    ins_mem_loader #(.INS_W(INS_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK           (clk),
        .RST           (rst),
        .Load_INS_en_in(load_en),
        .Rx_Valid_in   (rx_valid),
        .Rx_Byte_in    (rx_byte),
        .Fetch_en_in   (fetch_en),
        .PC_in         (pc),
        .INS_out       (ins_out),
        .INS_valid_out (ins_valid),
        .Load_done_out (load_done),
        .INS_count_out (ins_count),
        .Overflow_out  (overflow)
`ifdef INS_MEM_CHECKSUM_EN
        ,
        .Checksum_out  (checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             vld;
        logic [INS_W-1:0] ins;
    } exp_t;

    exp_t             sb[$];
    logic [7:0]       byte_q[$];
    logic [INS_W-1:0] held_ins;
    int               checks = 0;
    int               errors = 0;

    // Drive the bytes in byte_q as one session; optionally the first byte rides the start cycle.
    task automatic load_bytes(input bit first_on_start, input bit finish);
        int idx = 0;
        @(negedge clk);
        load_en  = 1'b1;
        rx_valid = 1'b0;
        if (first_on_start && byte_q.size() > 0) begin
            rx_valid = 1'b1;
            rx_byte  = byte_q[0];
            idx      = 1;
        end
        for (int i = idx; i < byte_q.size(); i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_byte  = byte_q[i];
        end
        @(negedge clk);
        rx_valid = 1'b0;
        if (finish) begin
            load_en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_fetch(input logic en, input logic [ADDR_W-1:0] p,
                            input logic v, input logic [INS_W-1:0] ins, input string nm);
        exp_t e;
        @(negedge clk);
        fetch_en = en;
        pc       = p;
        sb.push_back('{v, ins});
        @(negedge clk);
        fetch_en = 1'b0;
        e = sb.pop_front();
        checks += 2;
        if (ins_valid !== e.vld) begin
            errors++;
            $display("FAIL %s valid: got %b expected %b", nm, ins_valid, e.vld);
        end
        if (ins_out !== e.ins) begin
            errors++;
            $display("FAIL %s ins: got %h expected %h", nm, ins_out, e.ins);
        end
        held_ins = e.ins;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_en = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        fetch_en = 1'b0; pc = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks += 5;
        if (ins_out !== 16'h0) begin errors++; $display("FAIL reset_ins: got %h expected 0000", ins_out); end
        if (ins_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", ins_valid); end
        if (load_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", load_done); end
        if (ins_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", ins_count); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
`ifdef INS_MEM_CHECKSUM_EN
        checks++;
        if (checksum !== 8'h00) begin errors++; $display("FAIL reset_csum: got %h expected 00", checksum); end
`endif
        held_ins = 16'h0;
    endtask

    task automatic test_load_fetch();
        byte_q = '{8'h34, 8'h12, 8'h78, 8'h56};
        load_bytes(1'b0, 1'b1);
        checks += 3;
        if (ins_count !== 3'd2) begin errors++; $display("FAIL lf_count: got %0d expected 2", ins_count); end
        if (load_done !== 1'b1) begin errors++; $display("FAIL lf_done: got %b expected 1", load_done); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL lf_ovf: got %b expected 0", overflow); end
        do_fetch(1'b1, 2'd0, 1'b1, 16'h1234, "lf_pc0");
        do_fetch(1'b1, 2'd1, 1'b1, 16'h5678, "lf_pc1");
    endtask

    task automatic test_unloaded_fetch();
        do_fetch(1'b1, 2'd2, 1'b0, 16'h0000, "nop_pc2");
        do_fetch(1'b1, 2'd3, 1'b0, 16'h0000, "nop_pc3");
        do_fetch(1'b1, 2'd1, 1'b1, 16'h5678, "re_pc1");
        do_fetch(1'b0, 2'd0, 1'b0, held_ins, "hold_idle");
    endtask

    task automatic test_partial();
        byte_q = '{8'hAA, 8'hBB, 8'hCC};
        load_bytes(1'b0, 1'b1);
        checks++;
        if (ins_count !== 3'd1) begin errors++; $display("FAIL part_count: got %0d expected 1", ins_count); end
        do_fetch(1'b1, 2'd0, 1'b1, 16'hBBAA, "part_pc0");
        do_fetch(1'b1, 2'd1, 1'b0, 16'h0000, "part_pc1");
        // A byte offered while idle must not leak into the next session.
        @(negedge clk);
        rx_valid = 1'b1; rx_byte = 8'hEE;
        @(negedge clk);
        rx_valid = 1'b0;
        byte_q = '{8'h01, 8'h02};
        load_bytes(1'b1, 1'b1);
        checks++;
        if (ins_count !== 3'd1) begin errors++; $display("FAIL reload_count: got %0d expected 1", ins_count); end
        do_fetch(1'b1, 2'd0, 1'b1, 16'h0201, "reload_pc0");
    endtask

    task automatic test_overflow();
        byte_q = {};
        for (int i = 0; i < 10; i++) byte_q.push_back(8'(i));
        load_bytes(1'b0, 1'b1);
        checks += 3;
        if (ins_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", ins_count); end
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        if (load_done !== 1'b1) begin errors++; $display("FAIL ovf_done: got %b expected 1", load_done); end
        do_fetch(1'b1, 2'd3, 1'b1, 16'h0706, "ovf_pc3");
        do_fetch(1'b1, 2'd0, 1'b1, 16'h0100, "ovf_pc0");
    endtask

    task automatic test_fetch_during_load();
        // Fetch on the session-start cycle is ignored and the start clears status.
        @(negedge clk);
        load_en = 1'b1; fetch_en = 1'b1; pc = 2'd0;
        @(negedge clk);
        fetch_en = 1'b0;
        checks += 5;
        if (ins_valid !== 1'b0) begin errors++; $display("FAIL start_valid: got %b expected 0", ins_valid); end
        if (ins_out !== held_ins) begin errors++; $display("FAIL start_ins: got %h expected %h", ins_out, held_ins); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL start_ovf: got %b expected 0", overflow); end
        if (load_done !== 1'b0) begin errors++; $display("FAIL start_done: got %b expected 0", load_done); end
        if (ins_count !== 3'd0) begin errors++; $display("FAIL start_count: got %0d expected 0", ins_count); end
        byte_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};
        foreach (byte_q[i]) begin
            @(negedge clk);
            rx_valid = 1'b1; rx_byte = byte_q[i];
        end
        @(negedge clk);
        rx_valid = 1'b0;
        do_fetch(1'b1, 2'd0, 1'b0, held_ins, "load_fetch");
        checks++;
        if (ins_count !== 3'd3) begin errors++; $display("FAIL live_count: got %0d expected 3", ins_count); end
    endtask

    task automatic test_reset_mid_load();
        @(negedge clk);
        rst = 1'b1; load_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks += 5;
        if (ins_out !== 16'h0) begin errors++; $display("FAIL rst_ins: got %h expected 0000", ins_out); end
        if (ins_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", ins_valid); end
        if (load_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b expected 0", load_done); end
        if (ins_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", ins_count); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
        do_fetch(1'b1, 2'd0, 1'b0, 16'h0000, "rst_pc0");
    endtask

`ifdef INS_MEM_CHECKSUM_EN
    task automatic test_checksum();
        byte_q = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hFF};
        load_bytes(1'b0, 1'b1);
        checks += 2;
        if (checksum !== 8'h08) begin errors++; $display("FAIL csum: got %h expected 08", checksum); end
        if (ins_count !== 3'd2) begin errors++; $display("FAIL csum_count: got %0d expected 2", ins_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_load_fetch();
        test_unloaded_fetch();
        test_partial();
        test_overflow();
        test_fetch_during_load();
        test_reset_mid_load();
`ifdef INS_MEM_CHECKSUM_EN
        test_checksum();
`endif
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
